// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal sync response path: response kinds and the
// response arbiter states.
package fractal_sync_pkg;

    typedef enum logic [1:0] {
        GRANT   = 2'd0,
        ID_ERR  = 2'd1,
        OVF_ERR = 2'd2
    } rsp_kind_e;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fractal_sync_rsp_fifo.sv
// Small single-clock FIFO holding buffered responses of one RF port.
// A pop in the same cycle frees a slot, so a push into a full FIFO is
// admitted when the head leaves at the same time.
module fractal_sync_rsp_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push,
    input  entry_t data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1 so any depth works.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

endmodule

// File: rtl/fractal_sync_rsp_collector.sv
// Collects per-port RF results into per-port FIFOs and serialises them
// round-robin onto one valid/ready response channel. The RF cannot be
// stalled, so events that find their FIFO full are dropped and counted.
module fractal_sync_rsp_collector
    import fractal_sync_pkg::*;
#(
    parameter int  N_PORTS    = 2,
    parameter int  ID_WIDTH   = 1,
    parameter type element_t  = logic,
    parameter int  FIFO_DEPTH = 2,
    parameter int  CNT_WIDTH  = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]  id_i,
    input  logic [N_PORTS-1:0]                grant_i,
    input  element_t [N_PORTS-1:0]            element_i,
    input  logic [N_PORTS-1:0]                id_err_i,
    input  logic [N_PORTS-1:0]                overflow_error_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [$clog2(N_PORTS)-1:0]        rsp_port_o,
    output rsp_kind_e                         rsp_kind_o,
    output logic [ID_WIDTH-1:0]               rsp_id_o,
    output element_t                          rsp_element_o,
    output logic                              drop_o,
    output logic [CNT_WIDTH-1:0]              drop_cnt_o
);

    localparam int PORT_W  = $clog2(N_PORTS);
    localparam int NDROP_W = $clog2(N_PORTS + 1);
    localparam int SUM_W   = CNT_WIDTH + NDROP_W;
    localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_WIDTH{1'b1}});

    typedef struct packed {
        rsp_kind_e           kind;
        logic [ID_WIDTH-1:0] id;
        element_t            element;
    } rsp_entry_t;

    rsp_entry_t          push_entry [N_PORTS];
    rsp_entry_t          head       [N_PORTS];
    logic [N_PORTS-1:0]  evt;
    logic [N_PORTS-1:0]  full;
    logic [N_PORTS-1:0]  empty;
    logic [N_PORTS-1:0]  pop;
    logic [N_PORTS-1:0]  drop_vec;

    arb_state_e          state;
    arb_state_e          state_next;
    logic                locked;
    logic [PORT_W-1:0]   rr_ptr;
    logic [PORT_W-1:0]   locked_idx;
    logic [PORT_W-1:0]   search_idx;
    logic [PORT_W-1:0]   cand;
    logic [PORT_W-1:0]   winner;
    logic                found;
    logic                handshake;

    logic [NDROP_W-1:0]  ndrop;
    logic [SUM_W-1:0]    drop_sum;
    logic [CNT_WIDTH-1:0] drop_cnt_next;

    // Turn each port's RF flags into one entry, id error taking precedence over overflow over grant.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            evt[p] = id_err_i[p] | overflow_error_i[p] | grant_i[p];
            if (id_err_i[p]) begin
                push_entry[p].kind = ID_ERR;
            end else if (overflow_error_i[p]) begin
                push_entry[p].kind = OVF_ERR;
            end else begin
                push_entry[p].kind = GRANT;
            end
            push_entry[p].id      = id_i[p];
            push_entry[p].element = element_i[p];
            drop_vec[p] = evt[p] && full[p] && !pop[p];
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_fifo
        fractal_sync_rsp_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (rsp_entry_t)
        ) u_fifo (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .push  (evt[g]),
            .data  (push_entry[g]),
            .pop   (pop[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .head  (head[g])
        );
    end

    // Find the first non-empty port at or after the round-robin pointer, wrapping.
    always_comb begin
        search_idx = rr_ptr;
        cand       = rr_ptr;
        found      = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = PORT_W'((int'(rr_ptr) + i) % N_PORTS);
            if (!found && !empty[cand]) begin
                found      = 1'b1;
                search_idx = cand;
            end
        end
    end

    // Arbiter state register: HOLD freezes the presented winner until it is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ARB_FREE;
        end else begin
            state <= state_next;
        end
    end

    // Enter HOLD when a response is offered but not taken; leave on handshake.
    always_comb begin
        state_next = state;
        case (state)
            ARB_FREE: if (rsp_valid_o && !rsp_ready_i) state_next = ARB_HOLD;
            ARB_HOLD: if (rsp_ready_i) state_next = ARB_FREE;
            default:  state_next = ARB_FREE;
        endcase
    end

    // Arbiter outputs: lock indication, winner selection, handshake and per-port pop.
    always_comb begin
        locked      = (state == ARB_HOLD);
        winner      = locked ? locked_idx : search_idx;
        rsp_valid_o = |(~empty);
        handshake   = rsp_valid_o && rsp_ready_i;
        for (int p = 0; p < N_PORTS; p++) begin
            pop[p] = handshake && (winner == PORT_W'(p));
        end
    end

    // Remember which port was presented when the consumer first stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_idx <= '0;
        end else if (!locked && rsp_valid_o && !rsp_ready_i) begin
            locked_idx <= search_idx;
        end
    end

    // Advance the round-robin pointer past the winner only when a response is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (winner == PORT_W'(N_PORTS - 1)) ? '0 : winner + PORT_W'(1);
        end
    end

    // Present the winner's head; drive zeros while nothing is buffered.
    always_comb begin
        rsp_port_o    = '0;
        rsp_kind_o    = GRANT;
        rsp_id_o      = '0;
        rsp_element_o = '0;
        if (rsp_valid_o) begin
            rsp_port_o    = winner;
            rsp_kind_o    = head[winner].kind;
            rsp_id_o      = head[winner].id;
            rsp_element_o = head[winner].element;
        end
    end

    // Sum this cycle's dropped ports and saturate the running total.
    always_comb begin
        ndrop = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            ndrop = ndrop + NDROP_W'(drop_vec[p]);
        end
        drop_sum      = SUM_W'(drop_cnt_o) + SUM_W'(ndrop);
        drop_cnt_next = (drop_sum > SAT) ? '1 : drop_sum[CNT_WIDTH-1:0];
    end

    // Register the drop pulse and counter so no RF input reaches an output combinationally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_o     <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            drop_o     <= |drop_vec;
            drop_cnt_o <= drop_cnt_next;
        end
    end

endmodule

// File: tb/tb_fractal_sync_rsp_collector.sv
// Directed self-checking bench for fractal_sync_rsp_collector with
// 2 ports, 4-bit ids and elements, depth-2 FIFOs and a 2-bit drop counter.
module tb_fractal_sync_rsp_collector;
    import fractal_sync_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [1:0][3:0] id_i;
    logic [1:0]      grant_i;
    logic [1:0][3:0] element_i;
    logic [1:0]      id_err_i;
    logic [1:0]      overflow_error_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [0:0]      rsp_port_o;
    rsp_kind_e       rsp_kind_o;
    logic [3:0]      rsp_id_o;
    logic [3:0]      rsp_element_o;
    logic            drop_o;
    logic [1:0]      drop_cnt_o;

    logic [11:0]     rsp_bus;
    logic [11:0]     exp_bus;
    int              pass_cnt  = 0;
    int              total_cnt = 0;

    assign rsp_bus = {rsp_valid_o, rsp_port_o, rsp_kind_o, rsp_id_o, rsp_element_o};

    fractal_sync_rsp_collector #(
        .N_PORTS    (2),
        .ID_WIDTH   (4),
        .element_t  (logic [3:0]),
        .FIFO_DEPTH (2),
        .CNT_WIDTH  (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .id_i             (id_i),
        .grant_i          (grant_i),
        .element_i        (element_i),
        .id_err_i         (id_err_i),
        .overflow_error_i (overflow_error_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_port_o       (rsp_port_o),
        .rsp_kind_o       (rsp_kind_o),
        .rsp_id_o         (rsp_id_o),
        .rsp_element_o    (rsp_element_o),
        .drop_o           (drop_o),
        .drop_cnt_o       (drop_cnt_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        grant_i          = '0;
        id_err_i         = '0;
        overflow_error_i = '0;
        id_i             = '0;
        element_i        = '0;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        rsp_ready_i = 1'b0;
        idle_inputs();
        step();
        rst_i = 1'b0;
    endtask

    task automatic push_grant(input int port, input logic [3:0] id, input logic [3:0] elem);
        grant_i[port]   = 1'b1;
        id_i[port]      = id;
        element_i[port] = elem;
    endtask

    task automatic test_reset();
        do_reset();
        push_grant(0, 4'h1, 4'h1);
        push_grant(1, 4'h2, 4'h2);
        step();
        step();
        total_cnt++;
        if (rsp_valid_o !== 1'b1) $display("[TB] FAIL reset_pre_valid: got %b want 1", rsp_valid_o);
        else pass_cnt++;
        rst_i = 1'b1;
        step();
        step();
        exp_bus = '0;
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL reset_outputs: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        total_cnt++;
        if ({drop_o, drop_cnt_o} !== 3'b000) $display("[TB] FAIL reset_drop: got %b want 000", {drop_o, drop_cnt_o});
        else pass_cnt++;
        rst_i = 1'b0;
        idle_inputs();
        step();
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL reset_no_stale: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
    endtask

    task automatic test_single_grant();
        push_grant(1, 4'h5, 4'hA);
        rsp_ready_i = 1'b1;
        step();
        idle_inputs();
        exp_bus = {1'b1, 1'b1, GRANT, 4'h5, 4'hA};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL single_rsp: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL single_drained: got %b want 0", rsp_valid_o);
        else pass_cnt++;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        id_err_i[0]  = 1'b1;
        grant_i[0]   = 1'b1;
        id_i[0]      = 4'h3;
        element_i[0] = 4'h7;
        step();
        idle_inputs();
        exp_bus = {1'b1, 1'b0, ID_ERR, 4'h3, 4'h7};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL prio_id_err: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        rsp_ready_i = 1'b1;
        step();
        total_cnt++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL prio_single_entry: got %b want 0", rsp_valid_o);
        else pass_cnt++;
        rsp_ready_i         = 1'b0;
        overflow_error_i[1] = 1'b1;
        grant_i[1]          = 1'b1;
        id_i[1]             = 4'h9;
        element_i[1]        = 4'hC;
        step();
        idle_inputs();
        exp_bus = {1'b1, 1'b1, OVF_ERR, 4'h9, 4'hC};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL prio_ovf: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        rsp_ready_i = 1'b1;
        step();
        total_cnt++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL prio_ovf_drained: got %b want 0", rsp_valid_o);
        else pass_cnt++;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_rr_stability();
        do_reset();
        push_grant(0, 4'h1, 4'hE);
        push_grant(1, 4'h8, 4'h7);
        step();
        exp_bus = {1'b1, 1'b0, GRANT, 4'h1, 4'hE};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL rr_hold0: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        push_grant(0, 4'h2, 4'hD);
        push_grant(1, 4'h9, 4'h6);
        step();
        idle_inputs();
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL rr_hold1: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL rr_hold2: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        total_cnt++;
        if (drop_cnt_o !== 2'd0) $display("[TB] FAIL rr_no_drop: got %0d want 0", drop_cnt_o);
        else pass_cnt++;
        rsp_ready_i = 1'b1;
        step();
        exp_bus = {1'b1, 1'b1, GRANT, 4'h8, 4'h7};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL rr_order1: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        exp_bus = {1'b1, 1'b0, GRANT, 4'h2, 4'hD};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL rr_order2: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        exp_bus = {1'b1, 1'b1, GRANT, 4'h9, 4'h6};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL rr_order3: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL rr_drained: got %b want 0", rsp_valid_o);
        else pass_cnt++;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        push_grant(0, 4'h3, 4'h0);
        rsp_ready_i = 1'b1;
        step();
        idle_inputs();
        step();
        rsp_ready_i = 1'b0;
        push_grant(0, 4'h4, 4'h1);
        step();
        idle_inputs();
        exp_bus = {1'b1, 1'b0, GRANT, 4'h4, 4'h1};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL lock_first: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        push_grant(1, 4'h5, 4'h2);
        step();
        idle_inputs();
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL lock_held: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL lock_held2: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        rsp_ready_i = 1'b1;
        step();
        exp_bus = {1'b1, 1'b1, GRANT, 4'h5, 4'h2};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL lock_release: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL lock_drained: got %b want 0", rsp_valid_o);
        else pass_cnt++;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            push_grant(0, 4'(i), 4'(i));
            step();
            total_cnt++;
            if ({drop_o, drop_cnt_o} !== {(i >= 3), 2'((i >= 3) ? i - 2 : 0)})
                $display("[TB] FAIL ovf_push%0d: got drop=%b cnt=%0d want drop=%b cnt=%0d",
                         i, drop_o, drop_cnt_o, (i >= 3), (i >= 3) ? i - 2 : 0);
            else pass_cnt++;
        end
        idle_inputs();
        step();
        total_cnt++;
        if ({drop_o, drop_cnt_o} !== 3'b0_10) $display("[TB] FAIL ovf_idle: got %b want 010", {drop_o, drop_cnt_o});
        else pass_cnt++;
        push_grant(0, 4'h5, 4'h5);
        step();
        total_cnt++;
        if ({drop_o, drop_cnt_o} !== 3'b1_11) $display("[TB] FAIL ovf_cnt3: got %b want 111", {drop_o, drop_cnt_o});
        else pass_cnt++;
        push_grant(0, 4'h6, 4'h6);
        step();
        total_cnt++;
        if ({drop_o, drop_cnt_o} !== 3'b1_11) $display("[TB] FAIL ovf_saturate: got %b want 111", {drop_o, drop_cnt_o});
        else pass_cnt++;
        idle_inputs();
        step();
        total_cnt++;
        if ({drop_o, drop_cnt_o} !== 3'b0_11) $display("[TB] FAIL ovf_sat_hold: got %b want 011", {drop_o, drop_cnt_o});
        else pass_cnt++;
        exp_bus = {1'b1, 1'b0, GRANT, 4'h1, 4'h1};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL ovf_kept1: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        rsp_ready_i = 1'b1;
        step();
        exp_bus = {1'b1, 1'b0, GRANT, 4'h2, 4'h2};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL ovf_kept2: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL ovf_drained: got %b want 0", rsp_valid_o);
        else pass_cnt++;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        push_grant(0, 4'h1, 4'hB);
        step();
        push_grant(0, 4'h2, 4'hC);
        step();
        push_grant(0, 4'h3, 4'hD);
        rsp_ready_i = 1'b1;
        step();
        idle_inputs();
        total_cnt++;
        if (drop_o !== 1'b0) $display("[TB] FAIL fullpop_no_drop: got %b want 0", drop_o);
        else pass_cnt++;
        exp_bus = {1'b1, 1'b0, GRANT, 4'h2, 4'hC};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL fullpop_head2: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        exp_bus = {1'b1, 1'b0, GRANT, 4'h3, 4'hD};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL fullpop_head3: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({rsp_valid_o, drop_cnt_o} !== 3'b000) $display("[TB] FAIL fullpop_drained: got %b want 000", {rsp_valid_o, drop_cnt_o});
        else pass_cnt++;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_ready_idle();
        do_reset();
        rsp_ready_i = 1'b1;
        step();
        step();
        total_cnt++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL ready_idle_valid: got %b want 0", rsp_valid_o);
        else pass_cnt++;
        rsp_ready_i = 1'b0;
        push_grant(0, 4'h6, 4'h0);
        push_grant(1, 4'h7, 4'h0);
        step();
        idle_inputs();
        exp_bus = {1'b1, 1'b0, GRANT, 4'h6, 4'h0};
        total_cnt++;
        if (rsp_bus !== exp_bus) $display("[TB] FAIL ready_idle_first: got %h want %h", rsp_bus, exp_bus);
        else pass_cnt++;
        rsp_ready_i = 1'b1;
        step();
        step();
        total_cnt++;
        if (rsp_valid_o !== 1'b0) $display("[TB] FAIL ready_idle_drained: got %b want 0", rsp_valid_o);
        else pass_cnt++;
        rsp_ready_i = 1'b0;
    endtask

    // Run every scenario in order and report.
    initial begin
        rst_i       = 1'b1;
        rsp_ready_i = 1'b0;
        idle_inputs();
        test_reset();
        test_single_grant();
        test_priority();
        test_rr_stability();
        test_lock();
        test_overflow();
        test_full_pop();
        test_ready_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
